// File: rtl/output_router_pkg.sv
// Shared types and constants for the output router.
// - state_e : control FSM states (IDLE, PACK, FLUSH, DONE)
// - LANE_W  : lane counter width for the default element count per word
package output_router_pkg;

    localparam int DEF_DATA_LENGTH = 8;
    localparam int LANE_W          = $clog2(DEF_DATA_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/output_router_sipo_packer.sv
// Serial-in parallel-out packer: gathers DATA_LENGTH elements into one
// SPAD word (lane 0 in the LSBs) and emits a 1-cycle write strobe.
// Ports:
//   i_clk, i_nrst   clock, async active-low reset
//   i_clear         synchronous clear, drops any partial word/pending write
//   i_accept        element i_data is taken this cycle
//   i_last          accepted element is the final one of the route
//   o_wr_en         write strobe, one cycle after a word completes
//   o_wr_data       completed word, unused lanes zero
module sipo_packer
    import output_router_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 8,
    parameter int SPAD_DATA_WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_clear,
    input  logic                       i_accept,
    input  logic                       i_last,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_wr_en,
    output logic [SPAD_DATA_WIDTH-1:0] o_wr_data
);

    logic [LANE_W-1:0]          r_lane_cnt;
    logic [SPAD_DATA_WIDTH-1:0] r_pack_buf;
    logic [SPAD_DATA_WIDTH-1:0] r_wr_data;
    logic                       r_wr_en;
    logic [SPAD_DATA_WIDTH-1:0] w_word;
    logic                       w_word_end;

    // Buffer contents with the incoming element merged into its lane.
    always_comb begin
        w_word = r_pack_buf;
        w_word[r_lane_cnt*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end

    assign w_word_end = (r_lane_cnt == LANE_W'(DATA_LENGTH - 1)) || i_last;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_lane_cnt <= '0;
            r_pack_buf <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
        end else if (i_clear) begin
            r_lane_cnt <= '0;
            r_pack_buf <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_accept) begin
                if (w_word_end) begin
                    // Buffer was kept zero above the filled lanes, so a
                    // short final word is already zero-padded.
                    r_wr_data  <= w_word;
                    r_wr_en    <= 1'b1;
                    r_pack_buf <= '0;
                    r_lane_cnt <= '0;
                end else begin
                    r_pack_buf <= w_word;
                    r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                end
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_data = r_wr_data;

endmodule

// File: rtl/spad.sv
// Simple dual-port scratchpad: one synchronous write port and one
// synchronous read port with 1-cycle latency.
// Ports:
//   i_clk              clock
//   i_we/i_waddr/i_wdata   write strobe, address, data
//   i_re/i_raddr       read strobe and address
//   o_rdata            read data, valid the cycle after i_re
module spad #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: storage has no reset so it maps onto RAM macros; a reset
    // would force it into flops and a per-entry clear network.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // NOTE: non-blocking assignment means a same-cycle read of the
        // address being written sees the old contents.
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/output_router.sv
// Output router: collects a serial stream of PE-array results, packs them
// into SPAD words and writes them at consecutive addresses (wrapping)
// from a programmed start address. A read port lets the host drain them.
// Ports:
//   i_clk, i_nrst                  clock, async active-low reset
//   i_reg_clear                    synchronous clear back to IDLE
//   i_en, i_start_addr, i_route_size   start request and its parameters
//   i_data, i_data_valid, o_ready  element stream handshake
//   o_done, o_word_count           completion flag and words written
//   i_spad_read_en, i_read_addr    external read request
//   o_spad_data, o_spad_data_valid read data, 1 cycle after request
module output_router
    import output_router_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_en,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_route_size,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_data_valid,
    output logic                       o_ready,
    output logic                       o_done,
    output logic [ADDR_WIDTH-1:0]      o_word_count,
    input  logic                       i_spad_read_en,
    input  logic [ADDR_WIDTH-1:0]      i_read_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic                       o_spad_data_valid
);

    state_e                     r_state;
    state_e                     w_next_state;
    logic [ADDR_WIDTH-1:0]      r_start_addr;
    logic [ADDR_WIDTH-1:0]      r_route_size;
    logic [ADDR_WIDTH-1:0]      r_elem_cnt;
    logic [ADDR_WIDTH-1:0]      r_word_cnt;
    logic                       r_rd_valid;
    logic                       w_zero_size;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_wr_en;
    logic [SPAD_DATA_WIDTH-1:0] w_wr_data;
    logic [ADDR_WIDTH-1:0]      w_wr_addr;

    assign w_zero_size = (r_route_size == '0);
    assign o_ready     = (r_state == PACK);
    // A zero-length route never takes an element even though PACK is
    // visited for one cycle on the way to DONE.
    assign w_accept    = o_ready & i_data_valid & ~w_zero_size;
    assign w_last      = (r_elem_cnt == r_route_size - ADDR_WIDTH'(1));
    assign w_wr_addr   = r_start_addr + r_word_cnt;

    // NOTE: every output of this block is assigned a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (i_en) w_next_state = PACK;
            PACK: begin
                if (w_zero_size)            w_next_state = DONE;
                else if (w_accept && w_last) w_next_state = FLUSH;
            end
            FLUSH: w_next_state = DONE;
            DONE:  w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
        end else if (i_reg_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_start_addr <= '0;
            r_route_size <= '0;
            r_elem_cnt   <= '0;
            r_word_cnt   <= '0;
        end else if (i_reg_clear) begin
            r_start_addr <= '0;
            r_route_size <= '0;
            r_elem_cnt   <= '0;
            r_word_cnt   <= '0;
        end else begin
            if (r_state == IDLE && i_en) begin
                r_start_addr <= i_start_addr;
                r_route_size <= i_route_size;
                r_elem_cnt   <= '0;
                r_word_cnt   <= '0;
            end
            if (w_accept) begin
                r_elem_cnt <= r_elem_cnt + ADDR_WIDTH'(1);
            end
            // Word count advances on the edge the SPAD write commits.
            if (w_wr_en) begin
                r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_spad_read_en;
        end
    end

    sipo_packer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DATA_LENGTH    (DATA_LENGTH),
        .SPAD_DATA_WIDTH(SPAD_DATA_WIDTH)
    ) u_packer (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_clear  (i_reg_clear),
        .i_accept (w_accept),
        .i_last   (w_last),
        .i_data   (i_data),
        .o_wr_en  (w_wr_en),
        .o_wr_data(w_wr_data)
    );

    spad #(
        .DATA_WIDTH(SPAD_DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_spad (
        .i_clk  (i_clk),
        .i_we   (w_wr_en),
        .i_waddr(w_wr_addr),
        .i_wdata(w_wr_data),
        .i_re   (i_spad_read_en),
        .i_raddr(i_read_addr),
        .o_rdata(o_spad_data)
    );

    assign o_done            = (r_state == DONE);
    assign o_word_count      = r_word_cnt;
    assign o_spad_data_valid = r_rd_valid;

endmodule

// File: doc/output_router.md
Name: output_router

Overview:
- Write-side counterpart of the weight router: collects a serial stream of DATA_WIDTH results from the PE array.
- Packs DATA_LENGTH results into one SPAD_DATA_WIDTH word and writes each word into an internal output SPAD at consecutive addresses from a programmed start address.
- Exposes a read port so the host or DMA can drain the results.
- Sits between the PE array output and the host read-back path.

Parameters:
SPAD_DATA_WIDTH, 64, SPAD word width; must equal DATA_WIDTH*DATA_LENGTH
ADDR_WIDTH, 8, SPAD address and element-count width
DATA_WIDTH, 8, width of one result element
DATA_LENGTH, 8, elements per SPAD word

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_reg_clear  in  1  synchronous clear of all state back to IDLE
i_en  in  1  start request, sampled in IDLE
i_start_addr  in  ADDR_WIDTH  first SPAD word address
i_route_size  in  ADDR_WIDTH  total elements to collect
i_data  in  DATA_WIDTH  result element
i_data_valid  in  1  i_data qualifier
o_ready  out  1  block accepts elements this cycle
o_done  out  1  all words written; held until i_reg_clear
o_word_count  out  ADDR_WIDTH  SPAD words written so far
i_spad_read_en  in  1  external read request
i_read_addr  in  ADDR_WIDTH  external read address
o_spad_data  out  SPAD_DATA_WIDTH  read data
o_spad_data_valid  out  1  read data qualifier, 1 cycle after i_spad_read_en

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low on i_nrst. On reset: state IDLE; all counters, pack buffer and write register zero; o_ready=0, o_done=0, o_word_count=0, o_spad_data_valid=0. SPAD contents are not reset.
- FSM states: IDLE, PACK, FLUSH, DONE.
- IDLE -> PACK when i_en=1. On that edge, latch i_start_addr and i_route_size and zero the counters.
- If the latched route_size is 0: PACK -> DONE on the next edge; no SPAD write occurs.
- o_ready = (state==PACK). An element is accepted when o_ready & i_data_valid; i_data_valid is ignored in every other state.
- Packing order: element at lane_cnt goes to bits [lane_cnt*DATA_WIDTH +: DATA_WIDTH]. Lane 0 is the LSB.
- A word completes when lane_cnt==DATA_LENGTH-1, or when the accepted element is the last one (elem_cnt==route_size-1).
- On completion, the assembled word plus the new element is loaded into the write register, with unused lanes zero-padded. The pack buffer and lane_cnt clear. A 1-cycle SPAD write fires on the next cycle at address start_addr+word_cnt, modulo 2^ADDR_WIDTH, and word_cnt increments.
- Back-to-back acceptance every cycle is sustained; there are no bubbles.
- On acceptance of the last element: PACK -> FLUSH. The final write occurs during FLUSH. FLUSH -> DONE.
- o_done goes high on the edge after FLUSH (one cycle after last acceptance) and holds until i_reg_clear.
- o_word_count updates on the same edge the SPAD write commits.
- i_reg_clear in any state has priority over everything. The block returns to IDLE and clears counters, o_done and any pending write. An element presented in the same cycle is dropped.
- i_en outside IDLE is ignored.
- External read: 1-cycle latency, so o_spad_data_valid is i_spad_read_en delayed one cycle. Reads are allowed in any state. A read to the address being written in the same cycle returns the pre-write value.

Decomposition:
- Shared package holds typedef state_e (IDLE, PACK, FLUSH, DONE) and localparam LANE_W = $clog2(DATA_LENGTH).
- Reuse the existing spad module for storage.
- One natural sub-module: sipo_packer, which owns the lane counter, pack buffer, write register and write strobe.

Test Plan:
- Full words: start_addr=4, route_size=16, elements 0x01..0x10 back-to-back -> addr4=0x0807060504030201, addr5=0x100F0E0D0C0B0A09; o_word_count=2; o_done rises one cycle after the 16th element is accepted.
- Partial word: start_addr=0, route_size=3, elements 0xAA,0xBB,0xCC -> addr0=0x0000000000CCBBAA; o_word_count=1.
- Wrap and gaps: start_addr=0xFF, route_size=16, i_data_valid toggling every other cycle -> words written to 0xFF then 0x00; no element lost or duplicated.
- Zero size: route_size=0 with i_en -> o_done=1 with no SPAD write; o_word_count=0.
- Clear and reset mid-operation:
  - i_reg_clear after 5 of 16 elements -> IDLE, o_ready=0, no write to start_addr, o_done=0.
  - i_nrst low mid-PACK -> all outputs at reset values immediately.
- Read-back: after test 1, i_spad_read_en at addr5 -> o_spad_data=0x100F0E0D0C0B0A09 with o_spad_data_valid high exactly one cycle later.
